// File: rtl/agc_gain_controller_if.sv
// agc_gain_controller_if
//   Bundles the AGC loop signals between the ADC magnitude path / mapping
//   table side (master) and the gain controller (slave).
//   Optional feature macro: AGC_MANUAL_OVERRIDE_EN adds manual_en and manual_gain.
// Signals
//   enable        loop enable (master -> slave)
//   sample_valid  qualifies sample_mag (master -> slave)
//   sample_mag    unsigned sample magnitude, MAG_W bits (master -> slave)
//   gain_array    6-bit gain index (slave -> master)
//   gain_update   one-cycle pulse when gain_array changes (slave -> master)
//   locked        loop converged (slave -> master)
//   gain_sat      gain_array at 0 or MAX_GAIN (slave -> master)
//   manual_en     manual gain override request (master -> slave, optional)
//   manual_gain   manual gain index (master -> slave, optional)
interface agc_gain_controller_if #(
    parameter int MAG_W = 8
);
    logic             enable;
    logic             sample_valid;
    logic [MAG_W-1:0] sample_mag;
    logic [5:0]       gain_array;
    logic             gain_update;
    logic             locked;
    logic             gain_sat;
`ifdef AGC_MANUAL_OVERRIDE_EN
    logic             manual_en;
    logic [5:0]       manual_gain;
`endif

    modport master (
        output enable, sample_valid, sample_mag,
`ifdef AGC_MANUAL_OVERRIDE_EN
        output manual_en, manual_gain,
`endif
        input  gain_array, gain_update, locked, gain_sat
    );

    modport slave (
        input  enable, sample_valid, sample_mag,
`ifdef AGC_MANUAL_OVERRIDE_EN
        input  manual_en, manual_gain,
`endif
        output gain_array, gain_update, locked, gain_sat
    );
endinterface

// File: rtl/agc_gain_controller.sv
// agc_gain_controller
//   Closed-loop AGC sequencer. After every gain change it waits SETTLE_CYC
//   clocks for the VGA to settle, measures the peak magnitude over WIN_LEN
//   valid samples, then steps the gain index down (loud / saturated), up
//   (quiet) or counts towards lock (in range).
//   Optional feature macro: AGC_MANUAL_OVERRIDE_EN (manual gain override).
// Ports
//   clk   sole clock, rising edge
//   rst   synchronous active-high reset
//   bus   agc_gain_controller_if.slave: enable, sample_valid, sample_mag in;
//         gain_array, gain_update, locked, gain_sat out
module agc_gain_controller #(
    parameter int MAG_W       = 8,
    parameter int MAX_GAIN    = 38,
    parameter int INIT_GAIN   = 38,
    parameter int WIN_LEN     = 16,
    parameter int SETTLE_CYC  = 8,
    parameter int HI_THR      = 200,
    parameter int LO_THR      = 100,
    parameter int COARSE_STEP = 4,
    parameter int LOCK_COUNT  = 4
) (
    input logic                   clk,
    input logic                   rst,
    agc_gain_controller_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE,
        SETTLE,
        MEASURE,
        DECIDE
    } state_t;

    // One counter serves both the settle delay and the window sample count.
    localparam int CNT_MAX = (SETTLE_CYC > WIN_LEN) ? SETTLE_CYC : WIN_LEN;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam int LOCK_W  = $clog2(LOCK_COUNT + 1);

    localparam logic [5:0]       GAIN_MAX    = 6'(MAX_GAIN);
    // An out-of-range INIT_GAIN is pulled back to the legal ceiling.
    localparam logic [5:0]       GAIN_INIT   = (INIT_GAIN > MAX_GAIN) ? 6'(MAX_GAIN) : 6'(INIT_GAIN);
    localparam logic [5:0]       GAIN_COARSE = 6'(COARSE_STEP);
    localparam logic [MAG_W-1:0] MAG_FULL    = '1;
    localparam logic [MAG_W-1:0] MAG_HI      = MAG_W'(HI_THR);
    localparam logic [MAG_W-1:0] MAG_LO      = MAG_W'(LO_THR);
    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYC - 1);
    localparam logic [CNT_W-1:0] WIN_LAST    = CNT_W'(WIN_LEN - 1);
    localparam logic [LOCK_W-1:0] LOCK_FULL  = LOCK_W'(LOCK_COUNT);

    state_t             state, state_n;
    logic [CNT_W-1:0]   cnt, cnt_n;
    logic [MAG_W-1:0]   peak, peak_n;
    logic [5:0]         gain, gain_n;
    logic [LOCK_W-1:0]  lock_cnt, lock_cnt_n;
    logic               locked_q, locked_n;
    logic               update_q;
    logic               out_of_range;

    // NOTE: every signal written here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        state_n      = state;
        cnt_n        = cnt;
        peak_n       = peak;
        gain_n       = gain;
        lock_cnt_n   = lock_cnt;
        locked_n     = locked_q;
        out_of_range = 1'b0;

        case (state)
            IDLE: begin
                cnt_n  = '0;
                peak_n = '0;
                if (bus.enable) begin
                    state_n = SETTLE;
                end
            end

            SETTLE: begin
                // Samples are ignored while the VGA settles.
                if (cnt == SETTLE_LAST) begin
                    cnt_n   = '0;
                    peak_n  = '0;
                    state_n = MEASURE;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end

            MEASURE: begin
                // Invalid cycles simply stretch the window.
                if (bus.sample_valid) begin
                    if (bus.sample_mag > peak) begin
                        peak_n = bus.sample_mag;
                    end
                    if (cnt == WIN_LAST) begin
                        cnt_n   = '0;
                        state_n = DECIDE;
                    end else begin
                        cnt_n = cnt + 1'b1;
                    end
                end
            end

            DECIDE: begin
                cnt_n  = '0;
                peak_n = '0;
                if (peak == MAG_FULL) begin
                    out_of_range = 1'b1;
                    gain_n       = (gain >= GAIN_COARSE) ? (gain - GAIN_COARSE) : 6'd0;
                end else if (peak > MAG_HI) begin
                    out_of_range = 1'b1;
                    gain_n       = (gain != 6'd0) ? (gain - 6'd1) : 6'd0;
                end else if (peak < MAG_LO) begin
                    out_of_range = 1'b1;
                    gain_n       = (gain < GAIN_MAX) ? (gain + 6'd1) : GAIN_MAX;
                end else begin
                    lock_cnt_n = (lock_cnt == LOCK_FULL) ? lock_cnt : (lock_cnt + 1'b1);
                    locked_n   = locked_q | (lock_cnt_n == LOCK_FULL);
                end

                if (out_of_range) begin
                    lock_cnt_n = '0;
                    locked_n   = 1'b0;
                end

                // A clamp that leaves the gain unchanged needs no settling.
                state_n = (gain_n != gain) ? SETTLE : MEASURE;
            end

            default: state_n = IDLE;
        endcase

        // Disable wins over any same-cycle decision: discard the window, hold gain.
        if (!bus.enable) begin
            state_n    = IDLE;
            cnt_n      = '0;
            peak_n     = '0;
            gain_n     = gain;
            lock_cnt_n = '0;
            locked_n   = 1'b0;
        end

`ifdef AGC_MANUAL_OVERRIDE_EN
        // Manual override parks the loop in IDLE and tracks the clamped request.
        if (bus.manual_en) begin
            state_n    = IDLE;
            cnt_n      = '0;
            peak_n     = '0;
            gain_n     = (bus.manual_gain > GAIN_MAX) ? GAIN_MAX : bus.manual_gain;
            lock_cnt_n = '0;
            locked_n   = 1'b0;
        end
`endif
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= '0;
            peak     <= '0;
            gain     <= GAIN_INIT;
            update_q <= 1'b0;
            lock_cnt <= '0;
            locked_q <= 1'b0;
        end else begin
            state    <= state_n;
            cnt      <= cnt_n;
            peak     <= peak_n;
            gain     <= gain_n;
            update_q <= (gain_n != gain);
            lock_cnt <= lock_cnt_n;
            locked_q <= locked_n;
        end
    end

    assign bus.gain_array  = gain;
    assign bus.gain_update = update_q;
    assign bus.locked      = locked_q;
    assign bus.gain_sat    = (gain == 6'd0) || (gain == GAIN_MAX);

endmodule

// File: tb/tb_agc_gain_controller.sv
// tb_agc_gain_controller
//   Directed bench for agc_gain_controller at default parameters.
//   Window-level vectors live in a table; coarse descent, the climb to
//   MAX_GAIN, enable drop-out, stretched windows and mid-window reset are
//   hand-written sequences.
module tb_agc_gain_controller;

    logic clk = 1'b0;
    logic rst = 1'b1;

    agc_gain_controller_if #(.MAG_W(8)) bus ();

    agc_gain_controller dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [7:0] base;
        logic [7:0] peak;
        int         pos;
        logic [5:0] gain;
        logic       upd;
        logic       lock;
        logic       sat;
    } vec_t;

    vec_t vecs [18];

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drives one measurement window (optionally preceded by the settle
    // period) and stops just after the DECIDE edge.
    task automatic run_window(input logic [7:0] base, input logic [7:0] peak,
                              input int pos, input logic settle);
        if (settle) begin
            bus.sample_valid = 1'b0;
            for (int i = 0; i < 8; i++) tick();
        end
        for (int i = 0; i < 16; i++) begin
            bus.sample_valid = 1'b1;
            bus.sample_mag   = (i == pos) ? peak : base;
            tick();
        end
        bus.sample_valid = 1'b0;
        tick();
    endtask

    initial begin
        int   pulses;
        int   first;
        int   exp_g;
        logic settle;

        vecs[0]  = '{8'd150, 8'd150,  0, 6'd38, 1'b0, 1'b0, 1'b1};
        vecs[1]  = '{8'd120, 8'd200,  7, 6'd38, 1'b0, 1'b0, 1'b1};
        vecs[2]  = '{8'd100, 8'd100,  3, 6'd38, 1'b0, 1'b0, 1'b1};
        vecs[3]  = '{8'd150, 8'd150,  0, 6'd38, 1'b0, 1'b1, 1'b1};
        vecs[4]  = '{8'd150, 8'd150,  0, 6'd38, 1'b0, 1'b1, 1'b1};
        vecs[5]  = '{8'd150, 8'd210, 15, 6'd37, 1'b1, 1'b0, 1'b0};
        vecs[6]  = '{8'd150, 8'd150,  0, 6'd37, 1'b0, 1'b0, 1'b0};
        vecs[7]  = '{8'd150, 8'd150,  0, 6'd37, 1'b0, 1'b0, 1'b0};
        vecs[8]  = '{8'd150, 8'd150,  0, 6'd37, 1'b0, 1'b0, 1'b0};
        vecs[9]  = '{8'd150, 8'd150,  0, 6'd37, 1'b0, 1'b1, 1'b0};
        vecs[10] = '{8'd90,  8'd99,   9, 6'd38, 1'b1, 1'b0, 1'b1};
        vecs[11] = '{8'd150, 8'd201,  0, 6'd37, 1'b1, 1'b0, 1'b0};
        vecs[12] = '{8'd10,  8'd254,  4, 6'd36, 1'b1, 1'b0, 1'b0};
        vecs[13] = '{8'd10,  8'd255, 12, 6'd32, 1'b1, 1'b0, 1'b0};
        vecs[14] = '{8'd150, 8'd150,  0, 6'd32, 1'b0, 1'b0, 1'b0};
        vecs[15] = '{8'd150, 8'd150,  0, 6'd32, 1'b0, 1'b0, 1'b0};
        vecs[16] = '{8'd150, 8'd150,  0, 6'd32, 1'b0, 1'b0, 1'b0};
        vecs[17] = '{8'd150, 8'd150,  0, 6'd32, 1'b0, 1'b1, 1'b0};

        bus.enable       = 1'b0;
        bus.sample_valid = 1'b0;
        bus.sample_mag   = 8'd0;
`ifdef AGC_MANUAL_OVERRIDE_EN
        bus.manual_en    = 1'b0;
        bus.manual_gain  = 6'd0;
`endif

        // Reset state
        repeat (3) tick();
        check("reset gain", bus.gain_array, 38);
        check("reset update", bus.gain_update, 0);
        check("reset locked", bus.locked, 0);
        check("reset sat", bus.gain_sat, 1);

        // Coarse descent under saturated input, 25 clocks per step
        rst              = 1'b0;
        bus.enable       = 1'b1;
        bus.sample_valid = 1'b1;
        bus.sample_mag   = 8'd255;
        pulses = 0;
        for (int j = 1; j <= 293; j++) begin
            tick();
            if (bus.gain_update) begin
                pulses++;
                exp_g = 38 - 4 * pulses;
                if (exp_g < 0) exp_g = 0;
                check($sformatf("coarse gain step %0d", pulses), bus.gain_array, exp_g);
                check($sformatf("coarse timing step %0d", pulses), j, 26 + 25 * (pulses - 1));
            end
        end
        check("coarse pulse count", pulses, 10);
        check("coarse final gain", bus.gain_array, 0);
        check("coarse final sat", bus.gain_sat, 1);

        // Quiet input climbs one step per window up to MAX_GAIN
        settle = 1'b0;
        for (int g = 1; g <= 38; g++) begin
            run_window(8'd50, 8'd50, 0, settle);
            check($sformatf("climb gain %0d", g), bus.gain_array, g);
            check($sformatf("climb update %0d", g), bus.gain_update, 1);
            settle = 1'b1;
        end
        run_window(8'd50, 8'd50, 0, settle);
        check("climb clamp gain", bus.gain_array, 38);
        check("climb clamp update", bus.gain_update, 0);
        check("climb clamp sat", bus.gain_sat, 1);
        settle = 1'b0;

        // Window-level vector table: thresholds, lock, unlock, relock
        for (int v = 0; v < 18; v++) begin
            run_window(vecs[v].base, vecs[v].peak, vecs[v].pos, settle);
            check($sformatf("vec%0d gain", v), bus.gain_array, vecs[v].gain);
            check($sformatf("vec%0d update", v), bus.gain_update, vecs[v].upd);
            check($sformatf("vec%0d locked", v), bus.locked, vecs[v].lock);
            check($sformatf("vec%0d sat", v), bus.gain_sat, vecs[v].sat);
            settle = vecs[v].upd;
        end

        // Enable drop mid-window: IDLE, gain held, lock cleared
        for (int i = 0; i < 10; i++) begin
            bus.sample_valid = 1'b1;
            bus.sample_mag   = 8'd255;
            tick();
        end
        bus.enable = 1'b0;
        tick();
        check("disable locked", bus.locked, 0);
        check("disable gain", bus.gain_array, 32);
        check("disable update", bus.gain_update, 0);
        repeat (5) tick();
        check("disable gain held", bus.gain_array, 32);

        // Re-enable with 50% valid: fresh window stretched to 32 clocks
        bus.enable = 1'b1;
        first = 0;
        for (int j = 1; j <= 60 && first == 0; j++) begin
            bus.sample_valid = (j % 2 == 1);
            bus.sample_mag   = 8'd255;
            tick();
            if (bus.gain_update) first = j;
        end
        check("stretched window pulse cycle", first, 42);
        check("stretched window gain", bus.gain_array, 28);

        // Reset in the middle of a window
        bus.sample_valid = 1'b1;
        for (int i = 0; i < 12; i++) tick();
        rst = 1'b1;
        tick();
        check("midrst gain", bus.gain_array, 38);
        check("midrst locked", bus.locked, 0);
        check("midrst update", bus.gain_update, 0);
        check("midrst sat", bus.gain_sat, 1);

`ifdef AGC_MANUAL_OVERRIDE_EN
        // Manual override clamps and pulses only on change
        bus.manual_en   = 1'b1;
        bus.manual_gain = 6'd45;
        tick();
        check("manual clamp gain", bus.gain_array, 38);
        rst = 1'b0;
        tick();
        check("manual clamp gain held", bus.gain_array, 38);
        check("manual clamp update", bus.gain_update, 0);
        bus.manual_gain = 6'd12;
        tick();
        check("manual gain", bus.gain_array, 12);
        check("manual update", bus.gain_update, 1);
        check("manual locked", bus.locked, 0);
        tick();
        check("manual update drop", bus.gain_update, 0);
        bus.manual_en = 1'b0;
`endif

        rst = 1'b0;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
